// File: rtl/bubble_sort_seq.sv
// Sequential bubble sorter: one compare-exchange per clock on a shared comparator,
// with early exit when a full pass makes no swap. Valid/ready on both sides.
module bubble_sort_seq #(
    parameter int DIM   = 4,
    parameter int WIDTH = 8,
    localparam int CW   = ($clog2(DIM*(DIM-1)/2+1) < 1) ? 1 : $clog2(DIM*(DIM-1)/2+1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DIM*WIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DIM*WIDTH-1:0] out_data,
    output logic [CW-1:0]        out_swaps
);

    localparam int IW = (DIM > 1) ? $clog2(DIM) : 1;

    typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

    state_t               state;
    logic [DIM*WIDTH-1:0] arr;
    logic [IW-1:0]        idx;
    logic [IW-1:0]        last;
    logic                 pass_swapped;
    logic [CW-1:0]        swaps;

    logic [WIDTH-1:0]     a_lo;
    logic [WIDTH-1:0]     a_hi;
    logic                 do_swap;
    logic                 end_pass;

    // Shared comparator: pick the adjacent pair at idx.
    always_comb begin
        a_lo = '0;
        a_hi = '0;
        for (int i = 0; i < DIM-1; i++) begin
            if (idx == IW'(i)) begin
                a_lo = arr[i*WIDTH +: WIDTH];
                a_hi = arr[(i+1)*WIDTH +: WIDTH];
            end
        end
    end

    // Strict compare keeps equal elements in place, so the sort is stable.
    assign do_swap  = (a_lo > a_hi);
    assign end_pass = (idx == last - IW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            arr          <= '0;
            idx          <= '0;
            last         <= IW'(DIM-1);
            pass_swapped <= 1'b0;
            swaps        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        arr          <= in_data;
                        idx          <= '0;
                        last         <= IW'(DIM-1);
                        pass_swapped <= 1'b0;
                        swaps        <= '0;
                        state        <= (DIM == 1) ? DONE : SORT;
                    end
                end
                SORT: begin
                    if (do_swap) begin
                        for (int i = 0; i < DIM-1; i++) begin
                            if (idx == IW'(i)) begin
                                arr[i*WIDTH +: WIDTH]     <= a_hi;
                                arr[(i+1)*WIDTH +: WIDTH] <= a_lo;
                            end
                        end
                        swaps <= swaps + CW'(1);
                    end
                    pass_swapped <= pass_swapped | do_swap;
                    if (end_pass) begin
                        // This cycle's swap counts toward the pass, hence the OR.
                        if (last == IW'(1) || !(pass_swapped || do_swap)) begin
                            state <= DONE;
                        end else begin
                            last         <= last - IW'(1);
                            idx          <= '0;
                            pass_swapped <= 1'b0;
                        end
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = arr;
    assign out_swaps = swaps;

endmodule
